// File: rtl/parity_mem.sv
// Single-port 2**ADDR_WIDTH x (DATA_WIDTH+1) RAM storing {parity, data} per write.
// Each location carries a valid bit so that unwritten or reset locations read back as zero.
module parity_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH:0]   data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [DATA_WIDTH:0] encode_word(input logic [DATA_WIDTH-1:0] d);
        return {^d, d};
    endfunction

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic                wr_en;
    logic                rd_en;

    // A write wins over a simultaneous read; the read is simply dropped.
    assign wr_en = write;
    assign rd_en = read & ~write;

    // Array contents are data only and never reset; valid bits gate visibility instead.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[address] <= encode_word(data_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[address] <= 1'b1;
        end
    end

    // Read stage: one-cycle registered output, held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= valid[address] ? mem[address] : '0;
        end
    end

endmodule

// File: tb/tb_parity_mem.sv
// Directed self-checking bench for parity_mem: parity encoding, overwrite, boundaries,
// simultaneous strobes, asynchronous reset and output hold.
module tb_parity_mem;

    logic        clk;
    logic        rst;
    logic        write;
    logic        read;
    logic [7:0]  data_in;
    logic [15:0] address;
    logic [8:0]  data_out;

    int checks;
    int errors;

    parity_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .address  (address),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 9'h%03h expected 9'h%03h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        write   = 1'b1;
        read    = 1'b0;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        read    = 1'b1;
        write   = 1'b0;
        address = a;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    logic [15:0] bulk_addr [6];
    logic [7:0]  bulk_data [6];
    int          order [6] = '{3, 0, 5, 1, 4, 2};
    logic [8:0]  exp_word;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        address = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out", data_out, 9'h000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_read(16'h4321);
        check_val("unwritten", data_out, 9'h000);

        // Parity encoding
        do_write(16'h1234, 8'hA5);
        check_val("write_no_change", data_out, 9'h000);
        do_read(16'h1234);
        check_val("par_a5", data_out, 9'h0A5);
        do_write(16'hFFFF, 8'h07);
        do_read(16'hFFFF);
        check_val("par_07", data_out, 9'h107);

        // Hold for 3 idle clocks
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("hold", data_out, 9'h107);
        end

        // Random bulk: distinct addresses via index in top bits
        for (int i = 0; i < 6; i++) begin
            bulk_addr[i] = {i[2:0], 13'($urandom)};
            bulk_data[i] = 8'($urandom);
        end
        for (int i = 0; i < 6; i++) do_write(bulk_addr[i], bulk_data[i]);
        for (int k = 0; k < 6; k++) begin
            do_read(bulk_addr[order[k]]);
            exp_word = {^bulk_data[order[k]], bulk_data[order[k]]};
            check_val("bulk", data_out, exp_word);
        end

        // Overwrite and boundaries
        do_write(16'h0000, 8'h01);
        do_write(16'h0000, 8'hFF);
        do_read(16'h0000);
        check_val("overwrite", data_out, 9'h0FF);
        do_write(16'hFFFF, 8'h80);
        do_read(16'hFFFF);
        check_val("top_addr", data_out, 9'h180);

        // Back-to-back write then read
        do_write(16'h0042, 8'h0E);
        do_read(16'h0042);
        check_val("b2b", data_out, 9'h10E);

        // Simultaneous strobes: write wins, output holds
        do_read(16'h1234);
        check_val("pre_both", data_out, 9'h0A5);
        $display("note: driving read and write together (illegal stimulus)");
        read    = 1'b1;
        write   = 1'b1;
        data_in = 8'h3C;
        address = 16'h0010;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        check_val("both_hold", data_out, 9'h0A5);
        do_read(16'h0010);
        check_val("both_wrote", data_out, 9'h03C);

        // Asynchronous reset mid-run
        do_write(16'h0020, 8'h55);
        do_read(16'h0020);
        check_val("pre_rst", data_out, 9'h055);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async", data_out, 9'h000);
        // strobe while in reset must be ignored
        write   = 1'b1;
        address = 16'h0030;
        data_in = 8'h11;
        @(posedge clk);
        #1;
        write = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        do_read(16'h0020);
        check_val("post_rst_invalid", data_out, 9'h000);
        do_read(16'h0030);
        check_val("rst_write_ignored", data_out, 9'h000);
        do_write(16'h0020, 8'h03);
        do_read(16'h0020);
        check_val("post_rst_write", data_out, 9'h003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
